// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises an LFSR from incoming AXI-Stream
// words, then free-runs it and accumulates bit/word error and lock-loss statistics.
module prbs_checker #(
  parameter logic [31:0] POLY          = 32'h80000057,
  parameter int          ITERATIONS    = 1,
  parameter int          LOCK_COUNT    = 4,
  parameter int          UNLOCK_ERRORS = 8
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        clear_counters,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] bit_err_count,
  output logic [47:0] word_count,
  output logic [31:0] err_word_count,
  output logic [15:0] lock_loss_count
);

  typedef enum logic {SEARCH, LOCKED} state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    logic [31:0] s;
    s = x;
    for (int i = 0; i < ITERATIONS; i++) s = {s[30:0], ^(s & POLY)};
    return s;
  endfunction

  function automatic logic [5:0] popcnt(input logic [31:0] x);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, x[i]};
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pred_q, pred_d;
  logic        pred_valid_q, pred_valid_d;
  logic [7:0]  good_q, good_d, bad_q, bad_d;
  logic [31:0] bit_q, bit_d, errw_q, errw_d;
  logic [47:0] word_q, word_d;
  logic [15:0] loss_q, loss_d;
  logic        err_pulse_q, err_pulse_d;

  logic [31:0] err;
  logic [8:0]  good_inc, bad_inc;
  logic [32:0] bit_sum;

  assign err      = s_axis_tdata ^ pred_q;
  assign good_inc = {1'b0, good_q} + 9'd1;
  assign bad_inc  = {1'b0, bad_q} + 9'd1;
  assign bit_sum  = {1'b0, bit_q} + {27'd0, popcnt(err)};

  always_comb begin
    state_d      = state_q;
    pred_d       = pred_q;
    pred_valid_d = pred_valid_q;
    good_d       = good_q;
    bad_d        = bad_q;
    bit_d        = bit_q;
    word_d       = word_q;
    errw_d       = errw_q;
    loss_d       = loss_q;
    err_pulse_d  = 1'b0;
    if (s_axis_tvalid) begin
      case (state_q)
        SEARCH: begin
          pred_d       = lfsr_next(s_axis_tdata);
          pred_valid_d = 1'b1;
          // all-zero words never count as good, so a dead link cannot lock
          if (pred_valid_q && (s_axis_tdata == pred_q) && (s_axis_tdata != '0)) begin
            good_d = good_inc[7:0];
            if (good_inc == 9'(LOCK_COUNT)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          pred_d = lfsr_next(pred_q);
          word_d = (word_q == '1) ? word_q : word_q + 48'd1;
          if (err != '0) begin
            bit_d       = bit_sum[32] ? '1 : bit_sum[31:0];
            errw_d      = (errw_q == '1) ? errw_q : errw_q + 32'd1;
            err_pulse_d = 1'b1;
            bad_d       = bad_inc[7:0];
            if (bad_inc == 9'(UNLOCK_ERRORS)) begin
              state_d      = SEARCH;
              good_d       = '0;
              pred_valid_d = 1'b0;
              loss_d       = (loss_q == '1) ? loss_q : loss_q + 16'd1;
            end
          end else begin
            bad_d = '0;
          end
        end
      endcase
    end
    if (clear_counters) begin
      bit_d  = '0;
      word_d = '0;
      errw_d = '0;
      loss_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= SEARCH;
      pred_q       <= '0;
      pred_valid_q <= 1'b0;
      good_q       <= '0;
      bad_q        <= '0;
      bit_q        <= '0;
      word_q       <= '0;
      errw_q       <= '0;
      loss_q       <= '0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      pred_valid_q <= pred_valid_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      bit_q        <= bit_d;
      word_q       <= word_d;
      errw_q       <= errw_d;
      loss_q       <= loss_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign s_axis_tready   = 1'b1;
  assign locked          = (state_q == LOCKED);
  assign err_pulse       = err_pulse_q;
  assign bit_err_count   = bit_q;
  assign word_count      = word_q;
  assign err_word_count  = errw_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: stimulus pushes expected status snapshots,
// a monitor pops and compares one per accepted beat or probe cycle.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        clr = 1'b0;
  logic        probe = 1'b0;
  logic        tready, locked, err_pulse;
  logic [31:0] bit_err_count, err_word_count;
  logic [47:0] word_count;
  logic [15:0] lock_loss_count;

  prbs_checker dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .clear_counters(clr), .locked(locked), .err_pulse(err_pulse),
    .bit_err_count(bit_err_count), .word_count(word_count),
    .err_word_count(err_word_count), .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic        ep;
    logic [47:0] word;
    logic [31:0] bits;
    logic [31:0] errw;
    logic [15:0] loss;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  bit          done = 0;
  bit          fin_chk = 0;
  logic [31:0] g;

  function automatic logic [31:0] nxt(input logic [31:0] x);
    return {x[30:0], ^(x & 32'h80000057)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_counters();
    e.word = '0; e.bits = '0; e.errw = '0; e.loss = '0;
  endtask

  // One accepted beat; counted = checked while locked, lk_after = locked afterwards.
  task automatic beat(input logic [31:0] d, input bit counted, input int nbits,
                      input bit lk_after, input bit clr_in);
    tdata = d; tvalid = 1'b1; clr = clr_in;
    if (counted) e.word = e.word + 48'd1;
    if (nbits > 0) begin
      e.bits = e.bits + 32'(nbits);
      e.errw = e.errw + 32'd1;
    end
    e.ep = (nbits > 0);
    if (counted && !lk_after) e.loss = e.loss + 16'd1;
    e.lk = lk_after;
    if (clr_in) zero_counters();
    q.push_back(e);
    tick();
    tvalid = 1'b0; clr = 1'b0; e.ep = 1'b0;
  endtask

  task automatic snap(input bit clr_in);
    probe = 1'b1; clr = clr_in;
    if (clr_in) zero_counters();
    q.push_back(e);
    tick();
    probe = 1'b0; clr = 1'b0;
  endtask

  task automatic gap(input bit en);
    if (en && ($urandom_range(0, 9) < 3)) tick();
  endtask

  task automatic seed_lock(input bit gaps);
    for (int i = 1; i <= 5; i++) begin
      gap(gaps);
      beat(g, 0, 0, i == 5, 0);
      g = nxt(g);
    end
  endtask

  task automatic clean(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      gap(gaps);
      beat(g, 1, 0, 1, 0);
      g = nxt(g);
    end
  endtask

  // Monitor
  logic fire_q;
  always @(posedge clk) fire_q <= tvalid | probe;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (fire_q === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_underflow got 0 entries expected >=1");
      end else begin
        x = q.pop_front();
        cmp("locked", 64'(locked), 64'(x.lk));
        cmp("err_pulse", 64'(err_pulse), 64'(x.ep));
        cmp("word_count", 64'(word_count), 64'(x.word));
        cmp("bit_err_count", 64'(bit_err_count), 64'(x.bits));
        cmp("err_word_count", 64'(err_word_count), 64'(x.errw));
        cmp("lock_loss_count", 64'(lock_loss_count), 64'(x.loss));
      end
    end
    if (done && !fin_chk) begin
      fin_chk = 1;
      cmp("scoreboard_drained", 64'(q.size()), 64'd0);
    end
  end

  initial begin
    e = '{lk: 1'b0, ep: 1'b0, word: '0, bits: '0, errw: '0, loss: '0};
    repeat (3) tick();
    aresetn = 1'b1;
    snap(0);
    repeat (10) tick();
    snap(0);

    // Lock on a clean stream, then 100 checked words
    g = 32'hFFFFFFFF;
    seed_lock(0);
    clean(100, 0);
    snap(0);

    // Two flipped bits in a single word, then clean
    beat(g ^ 32'h0000_0081, 1, 2, 1, 0);
    g = nxt(g);
    clean(10, 0);
    snap(0);

    // Clear alone, then 8 garbage words force unlock
    snap(1);
    for (int i = 0; i < 8; i++) begin
      beat(32'h12345678, 1, $countones(32'h12345678 ^ g), i < 7, 0);
      g = nxt(g);
    end
    snap(0);

    // Relock and run with idle gaps
    snap(1);
    seed_lock(1);
    clean(40, 1);
    snap(0);

    // Reset mid-operation with a beat pending
    aresetn = 1'b0; tdata = g; tvalid = 1'b1;
    e = '{lk: 1'b0, ep: 1'b0, word: '0, bits: '0, errw: '0, loss: '0};
    q.push_back(e);
    tick();
    q.push_back(e);
    tick();
    aresetn = 1'b1; tvalid = 1'b0;

    // All-zero stream never locks
    for (int i = 0; i < 50; i++) beat(32'h0, 0, 0, 0, 0);
    snap(0);

    // Clear coincident with an erroneous locked beat drops its contribution
    seed_lock(0);
    clean(3, 0);
    beat(g ^ 32'h1, 1, 1, 1, 1);
    g = nxt(g);
    clean(1, 0);
    snap(0);

    done = 1;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
